// File: rtl/mem_port_arbiter_if.sv
// Generic memory-port bundle: a requester drives the master side, the port owner answers on the slave side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W/8-1:0] rmask;
  logic [DATA_W/8-1:0] wmask;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;
  logic                resp;

  modport master (
    output addr, rmask, wmask, wdata,
    input  rdata, resp
  );

  modport slave (
    input  addr, rmask, wmask, wdata,
    output rdata, resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between imem and dmem: one-entry capture buffer per side, one transaction in flight.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed dmem priority for alternating grants on conflicts.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  imem,
  mem_port_arbiter_if.slave  dmem,
  mem_port_arbiter_if.master mem
);

  localparam int MASK_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IMEM = 2'd1;
  localparam logic [1:0] OWN_DMEM = 2'd2;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  req_t              ibuf_q, ibuf_d;
  req_t              dbuf_q, dbuf_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] imem_rdata_q, imem_rdata_d;
  logic [DATA_W-1:0] dmem_rdata_q, dmem_rdata_d;

  logic i_pulse, d_pulse;
  logic grant_dmem;
  logic resp_fire;
  logic work_next;
  logic i_busy, d_busy;
  req_t i_new, d_new, sel;

  assign i_pulse = (|imem.rmask) || (|imem.wmask);
  assign d_pulse = (|dmem.rmask) || (|dmem.wmask);

  assign i_new = '{vld: 1'b1, addr: imem.addr, rmask: imem.rmask, wmask: imem.wmask, wdata: imem.wdata};
  assign d_new = '{vld: 1'b1, addr: dmem.addr, rmask: dmem.rmask, wmask: dmem.wmask, wdata: dmem.wdata};

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_q: 1 = dmem was granted most recently, 0 = imem (reset value).
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (ibuf_q.vld && dbuf_q.vld) begin
      grant_dmem = !last_grant_q;
    end else begin
      grant_dmem = dbuf_q.vld;
    end
  end
`else
  assign grant_dmem = dbuf_q.vld;
`endif

  assign sel       = grant_dmem ? dbuf_q : ibuf_q;
  assign resp_fire = (state_q == ST_WAIT) && mem.resp;
  // A pulse in the same cycle counts as work so the next ISSUE follows without an IDLE bubble.
  assign work_next = ibuf_q.vld || dbuf_q.vld || i_pulse || d_pulse;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ibuf_d       = ibuf_q;
    dbuf_d       = dbuf_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (work_next) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        owner_d     = grant_dmem ? OWN_DMEM : OWN_IMEM;
        mem_addr_d  = sel.addr;
        mem_wdata_d = sel.wdata;
        if (grant_dmem) begin
          dbuf_d.vld = 1'b0;
        end else begin
          ibuf_d.vld = 1'b0;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = grant_dmem;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem.resp) begin
          if (owner_q == OWN_IMEM) begin
            imem_rdata_d = mem.rdata;
          end else begin
            dmem_rdata_d = mem.rdata;
          end
          owner_d = OWN_NONE;
          state_d = work_next ? ST_ISSUE : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Captures come last so a pulse on the port being issued overwrites the cleared entry.
    if (i_pulse) begin
      ibuf_d = i_new;
    end
    if (d_pulse) begin
      dbuf_d = d_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      ibuf_q       <= '0;
      dbuf_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ibuf_q       <= ibuf_d;
      dbuf_q       <= dbuf_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign mem.addr  = (state_q == ST_ISSUE) ? sel.addr  : mem_addr_q;
  assign mem.wdata = (state_q == ST_ISSUE) ? sel.wdata : mem_wdata_q;
  assign mem.rmask = (state_q == ST_ISSUE) ? sel.rmask : '0;
  assign mem.wmask = (state_q == ST_ISSUE) ? sel.wmask : '0;

  assign imem.resp  = resp_fire && (owner_q == OWN_IMEM);
  assign dmem.resp  = resp_fire && (owner_q == OWN_DMEM);
  assign imem.rdata = imem.resp ? mem.rdata : imem_rdata_q;
  assign dmem.rdata = dmem.resp ? mem.rdata : dmem_rdata_q;

  // A port is busy from capture until its response; the response cycle itself accepts a new pulse.
  assign i_busy = ibuf_q.vld
               || ((state_q == ST_ISSUE) && !grant_dmem)
               || ((state_q == ST_WAIT) && (owner_q == OWN_IMEM) && !mem.resp);
  assign d_busy = dbuf_q.vld
               || ((state_q == ST_ISSUE) && grant_dmem)
               || ((state_q == ST_WAIT) && (owner_q == OWN_DMEM) && !mem.resp);

  always @(posedge clk) begin
    if (!rst) begin
      assert (!((|dmem.rmask) && (|dmem.wmask)));
      assert (!(i_pulse && i_busy));
      assert (!(d_pulse && d_busy));
      assert ((state_q != ST_ISSUE) || sel.vld);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) imem_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dmem_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .imem (imem_if),
    .dmem (dmem_if),
    .mem  (mem_if)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int resp_delay = -1;

  // Model: index 0 = imem, 1 = dmem
  bit          pend_v [2];
  logic [31:0] pend_addr [2];
  logic [3:0]  pend_rm [2];
  logic [3:0]  pend_wm [2];
  logic [31:0] pend_wd [2];
  bit          issuing;
  int          owner;
  bit          owner_wr;
  int          last_grant;
  logic [31:0] hold_addr, hold_wdata;
  logic [31:0] hold_rdata [2];
  bit          rd_known [2];

  logic [3:0]  s_mem_rmask, s_mem_wmask;
  logic [31:0] s_mem_addr, s_mem_wdata, s_irdata, s_drdata;
  logic        s_iresp, s_dresp;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      pend_v[p] = 0; hold_rdata[p] = '0; rd_known[p] = 1;
    end
    issuing = 0; owner = -1; owner_wr = 0; last_grant = 0;
    hold_addr = '0; hold_wdata = '0; resp_delay = -1;
  endtask

  function automatic int pick();
    if (pend_v[0] && pend_v[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      return 1 - last_grant;
`else
      return 1;
`endif
    end
    return pend_v[1] ? 1 : 0;
  endfunction

  task automatic clear_inputs();
    imem_if.rmask = '0; imem_if.wmask = '0; imem_if.addr = $urandom; imem_if.wdata = '0;
    dmem_if.rmask = '0; dmem_if.wmask = '0; dmem_if.addr = $urandom; dmem_if.wdata = $urandom;
    mem_if.resp = 1'b0; mem_if.rdata = $urandom;
  endtask

  // One clock: compare outputs with the model at negedge, advance the model, then drop pulses.
  task automatic step();
    int w;
    logic [3:0] e_rm, e_wm;
    logic [31:0] e_addr, e_wd;
    bit resp_now, e_ir, e_dr, ip, dp;
    @(negedge clk);
    w = pick();
    if (issuing) begin
      e_rm = pend_rm[w]; e_wm = pend_wm[w]; e_addr = pend_addr[w]; e_wd = pend_wd[w];
    end else begin
      e_rm = '0; e_wm = '0; e_addr = hold_addr; e_wd = hold_wdata;
    end
    resp_now = (owner >= 0) && !issuing && (mem_if.resp === 1'b1);
    e_ir = resp_now && (owner == 0);
    e_dr = resp_now && (owner == 1);
    s_mem_rmask = mem_if.rmask; s_mem_wmask = mem_if.wmask;
    s_mem_addr = mem_if.addr; s_mem_wdata = mem_if.wdata;
    s_iresp = imem_if.resp; s_dresp = dmem_if.resp;
    s_irdata = imem_if.rdata; s_drdata = dmem_if.rdata;

    checks++; if (s_mem_rmask !== e_rm) begin failures++; $display("FAIL mem_rmask cyc=%0d got=%h exp=%h", cyc, s_mem_rmask, e_rm); end
    checks++; if (s_mem_wmask !== e_wm) begin failures++; $display("FAIL mem_wmask cyc=%0d got=%h exp=%h", cyc, s_mem_wmask, e_wm); end
    checks++; if (s_mem_addr !== e_addr) begin failures++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, s_mem_addr, e_addr); end
    checks++; if (s_mem_wdata !== e_wd) begin failures++; $display("FAIL mem_wdata cyc=%0d got=%h exp=%h", cyc, s_mem_wdata, e_wd); end
    checks++; if (s_iresp !== e_ir) begin failures++; $display("FAIL imem_resp cyc=%0d got=%b exp=%b", cyc, s_iresp, e_ir); end
    checks++; if (s_dresp !== e_dr) begin failures++; $display("FAIL dmem_resp cyc=%0d got=%b exp=%b", cyc, s_dresp, e_dr); end
    if (e_ir) begin
      checks++; if (s_irdata !== mem_if.rdata) begin failures++; $display("FAIL imem_rdata cyc=%0d got=%h exp=%h", cyc, s_irdata, mem_if.rdata); end
    end else if (rd_known[0]) begin
      checks++; if (s_irdata !== hold_rdata[0]) begin failures++; $display("FAIL imem_rdata_hold cyc=%0d got=%h exp=%h", cyc, s_irdata, hold_rdata[0]); end
    end
    if (e_dr && !owner_wr) begin
      checks++; if (s_drdata !== mem_if.rdata) begin failures++; $display("FAIL dmem_rdata cyc=%0d got=%h exp=%h", cyc, s_drdata, mem_if.rdata); end
    end else if (!e_dr && rd_known[1]) begin
      checks++; if (s_drdata !== hold_rdata[1]) begin failures++; $display("FAIL dmem_rdata_hold cyc=%0d got=%h exp=%h", cyc, s_drdata, hold_rdata[1]); end
    end

    ip = (|imem_if.rmask) || (|imem_if.wmask);
    dp = (|dmem_if.rmask) || (|dmem_if.wmask);
    if (rst) begin
      model_reset();
    end else begin
      if (issuing) begin
        owner = w; owner_wr = (pend_wm[w] != 0);
        hold_addr = pend_addr[w]; hold_wdata = pend_wd[w];
        pend_v[w] = 0; last_grant = w; issuing = 0;
      end else if (resp_now) begin
        if (owner == 1 && owner_wr) rd_known[1] = 0;
        else begin hold_rdata[owner] = mem_if.rdata; rd_known[owner] = 1; end
        owner = -1;
        issuing = pend_v[0] || pend_v[1] || ip || dp;
      end else if (owner < 0) begin
        issuing = pend_v[0] || pend_v[1] || ip || dp;
      end
      if (ip) begin
        pend_v[0] = 1; pend_addr[0] = imem_if.addr; pend_rm[0] = imem_if.rmask;
        pend_wm[0] = imem_if.wmask; pend_wd[0] = imem_if.wdata;
      end
      if (dp) begin
        pend_v[1] = 1; pend_addr[1] = dmem_if.addr; pend_rm[1] = dmem_if.rmask;
        pend_wm[1] = dmem_if.wmask; pend_wd[1] = dmem_if.wdata;
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    checks++; if (s_mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", s_mem_addr); end
    checks++; if (s_mem_rmask !== 4'h0 || s_mem_wmask !== 4'h0) begin failures++; $display("FAIL reset_masks got=%h/%h exp=0/0", s_mem_rmask, s_mem_wmask); end
    checks++; if (s_irdata !== 32'h0 || s_drdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", s_irdata, s_drdata); end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    imem_if.rmask = 4'hF; imem_if.addr = 32'h1000;
    step();
    step();
    checks++; if (s_mem_rmask !== 4'hF || s_mem_addr !== 32'h1000) begin failures++; $display("FAIL fetch_issue got=%h@%h exp=f@1000", s_mem_rmask, s_mem_addr); end
    step();
    checks++; if (s_mem_rmask !== 4'h0) begin failures++; $display("FAIL fetch_one_cycle got=%h exp=0", s_mem_rmask); end
    mem_if.resp = 1'b1; mem_if.rdata = 32'h13;
    step();
    checks++; if (s_iresp !== 1'b1 || s_irdata !== 32'h13 || s_dresp !== 1'b0) begin failures++; $display("FAIL fetch_resp got=%b/%h/%b exp=1/13/0", s_iresp, s_irdata, s_dresp); end
    step();
  endtask

  task automatic conflict(input logic [31:0] i_addr, input logic [31:0] d_addr, output logic [31:0] first_addr);
    imem_if.rmask = 4'hF; imem_if.addr = i_addr;
    dmem_if.wmask = 4'h3; dmem_if.addr = d_addr; dmem_if.wdata = 32'hBEEF;
    step();
    step();
    first_addr = s_mem_addr;
    mem_if.resp = 1'b1;
    step();
    step();
    mem_if.resp = 1'b1;
    step();
  endtask

  task automatic test_priority();
    logic [31:0] first;
    do_reset();
    conflict(32'h1000, 32'h2000, first);
    checks++; if (first !== 32'h2000) begin failures++; $display("FAIL conflict1_first got=%h exp=2000", first); end
    // A lone dmem write leaves dmem as the most recent grant before the second conflict.
    dmem_if.wmask = 4'hF; dmem_if.addr = 32'h2100; dmem_if.wdata = 32'h55;
    step(); step();
    mem_if.resp = 1'b1;
    step();
    conflict(32'h1000, 32'h2000, first);
`ifdef ARB_ROUND_ROBIN_EN
    checks++; if (first !== 32'h1000) begin failures++; $display("FAIL conflict2_first got=%h exp=1000", first); end
`else
    checks++; if (first !== 32'h2000) begin failures++; $display("FAIL conflict2_first got=%h exp=2000", first); end
`endif
  endtask

  task automatic test_capture_in_wait();
    dmem_if.rmask = 4'hF; dmem_if.addr = 32'h3000;
    step();
    step();
    imem_if.rmask = 4'hF; imem_if.addr = 32'h1004;
    step();
    repeat (4) step();
    mem_if.resp = 1'b1; mem_if.rdata = 32'hA5A5_0001;
    step();
    checks++; if (s_dresp !== 1'b1 || s_drdata !== 32'hA5A5_0001) begin failures++; $display("FAIL wait_dresp got=%b/%h exp=1/a5a50001", s_dresp, s_drdata); end
    step();
    checks++; if (s_mem_addr !== 32'h1004 || s_mem_rmask !== 4'hF) begin failures++; $display("FAIL wait_next_issue got=%h@%h exp=f@1004", s_mem_rmask, s_mem_addr); end
    mem_if.resp = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    imem_if.rmask = 4'hF; imem_if.addr = 32'h1000;
    step(); step();
    mem_if.resp = 1'b1; mem_if.rdata = 32'h0000_0093;
    imem_if.rmask = 4'hF; imem_if.addr = 32'h1008;
    step();
    checks++; if (s_iresp !== 1'b1) begin failures++; $display("FAIL collide_resp got=%b exp=1", s_iresp); end
    step();
    checks++; if (s_mem_addr !== 32'h1008 || s_mem_rmask !== 4'hF) begin failures++; $display("FAIL collide_issue got=%h@%h exp=f@1008", s_mem_rmask, s_mem_addr); end
    mem_if.resp = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_op();
    dmem_if.rmask = 4'hF; dmem_if.addr = 32'h3300;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_if.resp = 1'b1; mem_if.rdata = 32'h1234_5678;
    step();
    checks++; if (s_iresp !== 1'b0 || s_dresp !== 1'b0) begin failures++; $display("FAIL stray_resp got=%b/%b exp=0/0", s_iresp, s_dresp); end
    checks++; if ((s_mem_addr | s_mem_wdata | s_irdata | s_drdata) !== 32'h0 || (s_mem_rmask | s_mem_wmask) !== 4'h0) begin failures++; $display("FAIL stray_outputs got=%h/%h/%h/%h exp=0", s_mem_addr, s_mem_wdata, s_irdata, s_drdata); end
    imem_if.rmask = 4'hF; imem_if.addr = 32'h1100;
    step(); step();
    checks++; if (s_mem_addr !== 32'h1100 || s_mem_rmask !== 4'hF) begin failures++; $display("FAIL post_reset_issue got=%h@%h exp=f@1100", s_mem_rmask, s_mem_addr); end
    mem_if.resp = 1'b1; mem_if.rdata = 32'h77;
    step();
    checks++; if (s_iresp !== 1'b1 || s_irdata !== 32'h77) begin failures++; $display("FAIL post_reset_resp got=%b/%h exp=1/77", s_iresp, s_irdata); end
  endtask

  task automatic test_write();
    dmem_if.wmask = 4'hF; dmem_if.wdata = 32'hDEADBEEF; dmem_if.addr = 32'h4000;
    step(); step();
    checks++; if (s_mem_wmask !== 4'hF || s_mem_wdata !== 32'hDEADBEEF || s_mem_rmask !== 4'h0) begin failures++; $display("FAIL write_issue got=%h/%h/%h exp=f/deadbeef/0", s_mem_wmask, s_mem_wdata, s_mem_rmask); end
    step();
    checks++; if (s_mem_wmask !== 4'h0) begin failures++; $display("FAIL write_one_cycle got=%h exp=0", s_mem_wmask); end
    mem_if.resp = 1'b1;
    step();
    checks++; if (s_dresp !== 1'b1) begin failures++; $display("FAIL write_resp got=%b exp=1", s_dresp); end
  endtask

  task automatic test_random();
    int resp_to;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (owner >= 0 && !issuing) begin
        if (resp_delay < 0) resp_delay = $urandom_range(0, 3);
        if (resp_delay == 0) begin
          mem_if.resp = 1'b1; mem_if.rdata = $urandom; resp_delay = -1;
        end else begin
          resp_delay--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        mem_if.resp = 1'b1; mem_if.rdata = $urandom;
      end
      resp_to = (mem_if.resp && owner >= 0 && !issuing) ? owner : -1;
      if (((!pend_v[0] && owner != 0) || resp_to == 0) && $urandom_range(0, 2) == 0) begin
        imem_if.rmask = 4'hF; imem_if.addr = $urandom & 32'hFFFF_FFFC;
      end
      if (((!pend_v[1] && owner != 1) || resp_to == 1) && $urandom_range(0, 2) == 0) begin
        dmem_if.addr = $urandom; dmem_if.wdata = $urandom;
        if ($urandom_range(0, 1) == 0) dmem_if.rmask = 4'($urandom_range(1, 15));
        else dmem_if.wmask = 4'($urandom_range(1, 15));
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_capture_in_wait();
    test_back_to_back();
    test_reset_mid_op();
    test_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
